// File: rtl/proc_control_fsm.sv
// ---------------------------------------------------------------------------
// proc_control_fsm
// Control unit for the 16-bit, 8-register processor datapath. On a Run
// handshake it latches a 9-bit instruction from DIN. It then steps
// IDLE -> T1 (-> T2 -> T3) and decodes the datapath controls from the
// state and the latched instruction.
//
// Ports
//   Clock      in   system clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   Run        in   start request, sampled only in IDLE
//   DIN        in   instruction word / mvi immediate (bits [IW-1:0] latched)
//   Rin        out  one-hot register write enables R0..R7
//   BusSel     out  bus source: 0-7 = R0..R7, 8 = DIN, 9 = G, 15 = none
//   Ain        out  load A from bus
//   Gin        out  load G from ALU result
//   AluOp      out  ALU operation (latched opcode, 0 in IDLE)
//   Done       out  final cycle of an instruction
//   Busy       out  high whenever not in IDLE
//   IR         out  latched instruction
//   InstrCount out  retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module proc_control_fsm #(
   parameter int IW = 9,
   parameter int CW = 16
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          Run,
   input  logic [15:0]   DIN,
   output logic [7:0]    Rin,
   output logic [3:0]    BusSel,
   output logic          Ain,
   output logic          Gin,
   output logic [2:0]    AluOp,
   output logic          Done,
   output logic          Busy,
   output logic [IW-1:0] IR,
   output logic [CW-1:0] InstrCount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2,
      T3   = 2'd3
   } state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;

   localparam logic [3:0] SEL_DIN  = 4'd8;
   localparam logic [3:0] SEL_G    = 4'd9;
   localparam logic [3:0] SEL_NONE = 4'd15;

   state_t          state_q, state_d;
   logic [IW-1:0]   ir_q, ir_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [2:0]      op, rx, ry;

   // The upper DIN bits only carry immediate data to the bus, never control.
   logic            unused_din;
   assign unused_din = ^DIN[15:IW];

   assign op = ir_q[8:6];
   assign rx = ir_q[5:3];
   assign ry = ir_q[2:0];

   function automatic logic [7:0] onehot(input logic [2:0] idx);
      onehot = 8'b0000_0001 << idx;
   endfunction

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   // Controls depend only on registered state/IR, so an asynchronous reset
   // forces them inactive immediately without waiting for a clock edge.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      Rin     = '0;
      BusSel  = SEL_NONE;
      Ain     = 1'b0;
      Gin     = 1'b0;
      AluOp   = '0;
      Done    = 1'b0;
      Busy    = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            if (Run) begin
               ir_d    = DIN[IW-1:0];
               state_d = T1;
            end
         end
         T1: begin
            AluOp = op;
            if (op == OP_MV) begin
               Rin     = onehot(rx);
               BusSel  = {1'b0, ry};
               Done    = 1'b1;
               state_d = IDLE;
            end else if (op == OP_MVI) begin
               Rin     = onehot(rx);
               BusSel  = SEL_DIN;
               Done    = 1'b1;
               state_d = IDLE;
            end else begin
               BusSel  = {1'b0, rx};
               Ain     = 1'b1;
               state_d = T2;
            end
         end
         T2: begin
            // Only ALU opcodes ever reach T2.
            AluOp   = op;
            BusSel  = {1'b0, ry};
            Gin     = 1'b1;
            state_d = T3;
         end
         T3: begin
            AluOp   = op;
            BusSel  = SEL_G;
            Rin     = onehot(rx);
            Done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Retire on the edge that closes the Done cycle.
      if (Done) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign IR         = ir_q;
   assign InstrCount = cnt_q;

endmodule

// File: tb/tb_proc_control_fsm.sv
module tb_proc_control_fsm;

   logic        Clock;
   logic        Resetn;
   logic        Run, Run4;
   logic [15:0] DIN, DIN4;

   logic [7:0]  Rin, Rin4;
   logic [3:0]  BusSel, BusSel4;
   logic        Ain, Ain4, Gin, Gin4, Done, Done4, Busy, Busy4;
   logic [2:0]  AluOp, AluOp4;
   logic [8:0]  IR, IR4;
   logic [15:0] InstrCount;
   logic [3:0]  InstrCount4;

   proc_control_fsm #(.IW(9), .CW(16)) dut (
      .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
      .Rin(Rin), .BusSel(BusSel), .Ain(Ain), .Gin(Gin), .AluOp(AluOp),
      .Done(Done), .Busy(Busy), .IR(IR), .InstrCount(InstrCount)
   );

   proc_control_fsm #(.IW(9), .CW(4)) dut4 (
      .Clock(Clock), .Resetn(Resetn), .Run(Run4), .DIN(DIN4),
      .Rin(Rin4), .BusSel(BusSel4), .Ain(Ain4), .Gin(Gin4), .AluOp(AluOp4),
      .Done(Done4), .Busy(Busy4), .IR(IR4), .InstrCount(InstrCount4)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   typedef struct {
      logic        run;
      logic [15:0] din;
      logic [7:0]  rin;
      logic [3:0]  bs;
      logic        ain;
      logic        gin;
      logic [2:0]  alu;
      logic        done;
      logic        busy;
      logic [8:0]  ir;
      logic [15:0] cnt;
   } vec_t;

   function automatic vec_t mk(input logic run, input logic [15:0] din,
                               input logic [7:0] rin, input logic [3:0] bs,
                               input logic ain, input logic gin, input logic [2:0] alu,
                               input logic done, input logic busy,
                               input logic [8:0] ir, input logic [15:0] cnt);
      vec_t v;
      v.run = run; v.din = din; v.rin = rin; v.bs = bs; v.ain = ain; v.gin = gin;
      v.alu = alu; v.done = done; v.busy = busy; v.ir = ir; v.cnt = cnt;
      return v;
   endfunction

   localparam int NV = 23;
   vec_t tv [NV];

   int multihot = 0;
   int excl_err = 0;

   initial begin
      //         run din      rin    bs    ain gin alu  done busy ir       cnt
      tv[0]  = mk(1, 16'h048, 8'h00, 4'hF, 0, 0, 3'd0, 0, 0, 9'h000, 16'd0); // IDLE, latch mvi R1
      tv[1]  = mk(0, 16'h0A5, 8'h02, 4'h8, 0, 0, 3'd1, 1, 1, 9'h048, 16'd0); // mvi T1
      tv[2]  = mk(1, 16'h090, 8'h00, 4'hF, 0, 0, 3'd0, 0, 0, 9'h048, 16'd1); // latch add R2,R0
      tv[3]  = mk(0, 16'h000, 8'h00, 4'h2, 1, 0, 3'd2, 0, 1, 9'h090, 16'd1);
      tv[4]  = mk(0, 16'h1FF, 8'h00, 4'h0, 0, 1, 3'd2, 0, 1, 9'h090, 16'd1);
      tv[5]  = mk(0, 16'h000, 8'h04, 4'h9, 0, 0, 3'd2, 1, 1, 9'h090, 16'd1);
      tv[6]  = mk(1, 16'h038, 8'h00, 4'hF, 0, 0, 3'd0, 0, 0, 9'h090, 16'd2); // latch mv R7,R0
      tv[7]  = mk(1, 16'h0CA, 8'h80, 4'h0, 0, 0, 3'd0, 1, 1, 9'h038, 16'd2); // Run held, not sampled
      tv[8]  = mk(1, 16'h0CA, 8'h00, 4'hF, 0, 0, 3'd0, 0, 0, 9'h038, 16'd3); // latch sub R1,R2
      tv[9]  = mk(1, 16'h1FF, 8'h00, 4'h1, 1, 0, 3'd3, 0, 1, 9'h0CA, 16'd3);
      tv[10] = mk(0, 16'h1FF, 8'h00, 4'h2, 0, 1, 3'd3, 0, 1, 9'h0CA, 16'd3);
      tv[11] = mk(0, 16'h000, 8'h02, 4'h9, 0, 0, 3'd3, 1, 1, 9'h0CA, 16'd3);
      tv[12] = mk(1, 16'h16B, 8'h00, 4'hF, 0, 0, 3'd0, 0, 0, 9'h0CA, 16'd4); // latch slt R5,R3
      tv[13] = mk(0, 16'h000, 8'h00, 4'h5, 1, 0, 3'd5, 0, 1, 9'h16B, 16'd4); // Run dropped in T1
      tv[14] = mk(0, 16'h000, 8'h00, 4'h3, 0, 1, 3'd5, 0, 1, 9'h16B, 16'd4);
      tv[15] = mk(0, 16'h000, 8'h20, 4'h9, 0, 0, 3'd5, 1, 1, 9'h16B, 16'd4);
      tv[16] = mk(0, 16'h090, 8'h00, 4'hF, 0, 0, 3'd0, 0, 0, 9'h16B, 16'd5);
      tv[17] = mk(0, 16'h090, 8'h00, 4'hF, 0, 0, 3'd0, 0, 0, 9'h16B, 16'd5);
      tv[18] = mk(1, 16'h09B, 8'h00, 4'hF, 0, 0, 3'd0, 0, 0, 9'h16B, 16'd5); // latch add R3,R3
      tv[19] = mk(0, 16'h000, 8'h00, 4'h3, 1, 0, 3'd2, 0, 1, 9'h09B, 16'd5);
      tv[20] = mk(0, 16'h000, 8'h00, 4'h3, 0, 1, 3'd2, 0, 1, 9'h09B, 16'd5);
      tv[21] = mk(0, 16'h000, 8'h08, 4'h9, 0, 0, 3'd2, 1, 1, 9'h09B, 16'd5);
      tv[22] = mk(0, 16'h000, 8'h00, 4'hF, 0, 0, 3'd0, 0, 0, 9'h09B, 16'd6);

      // Reset asserted with a definite falling edge, checked before any clock edge.
      Resetn = 1'b1; Run = 1'b0; DIN = '0; Run4 = 1'b0; DIN4 = '0;
      #1 Resetn = 1'b0;
      #1;
      check("reset_ctrl", {Rin, BusSel, Ain, Gin, AluOp, Done, Busy}, {8'h00, 4'hF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
      check("reset_ir_cnt", {IR, InstrCount}, {9'h000, 16'd0});
      step();
      step();
      Resetn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         Run = tv[i].run;
         DIN = tv[i].din;
         #1;
         check($sformatf("vec%0d", i),
               {Rin, BusSel, Ain, Gin, AluOp, Done, Busy, IR, InstrCount},
               {tv[i].rin, tv[i].bs, tv[i].ain, tv[i].gin, tv[i].alu,
                tv[i].done, tv[i].busy, tv[i].ir, tv[i].cnt});
         if ($countones(Rin) > 1) multihot++;
         if ((int'(Ain) + int'(Gin) + int'(Done)) > 1) excl_err++;
         step();
      end
      check("main_rin_multihot", 64'(multihot), 64'd0);
      check("main_ain_gin_done_excl", 64'(excl_err), 64'd0);

      // Reset in T2 of an add: controls must drop with no edge.
      Run = 1'b1; DIN = 16'h090;
      step();                       // T1
      Run = 1'b0;
      step();                       // T2
      check("pre_reset_t2_gin", {Gin, BusSel}, {1'b1, 4'h0});
      #2 Resetn = 1'b0;
      #1;
      check("async_reset_ctrl", {Rin, BusSel, Ain, Gin, AluOp, Done, Busy}, {8'h00, 4'hF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
      check("async_reset_cnt", {IR, InstrCount}, {9'h000, 16'd0});
      step();
      step();
      Resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("post_reset_idle%0d", i), {Done, Rin, Busy, InstrCount}, {1'b0, 8'h00, 1'b0, 16'd0});
      end

      // Wrap of a 4-bit counter over 16 back-to-back mv instructions.
      multihot = 0;
      Run4 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         DIN4 = {7'd0, 3'b000, i[2:0], 3'b000};
         step();                    // T1
         if (i == 0 || i == 15)
            check($sformatf("wrap_done%0d", i), {Done4, Rin4}, {1'b1, 8'(8'h01 << i[2:0])});
         if ($countones(Rin4) > 1) multihot++;
         step();                    // back to IDLE, retired
         if ($countones(Rin4) > 1) multihot++;
         if (i == 14) check("wrap_cnt15", 64'(InstrCount4), 64'd15);
      end
      Run4 = 1'b0;
      check("wrap_cnt0", 64'(InstrCount4), 64'd0);
      check("wrap_rin_multihot", 64'(multihot), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
